grammar_responder: RTL and testbench
====================================

# grammar_responder

Transmit-side companion to the grammar validator. Watches the validator's `accept`/`reject` outputs and, for each new verdict, serialises an ASCII response string ("OK\r\n" or "ERR\r\n") byte-by-byte to the serial transmitter over a valid/ready handshake. Sits between the validator outputs and the UART TX byte interface, so the host receives a reply for every word the validator judges.

## Interface
Parameters:
- `CNT_W`, 8: width of `sent_count` and `drop_count`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `accept`  in  1  validator accept level.
- `reject`  in  1  validator reject level.
- `tx_data`  out  8  response byte offered to the transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter takes the byte this cycle.
- `busy`  out  1  a message is in progress or one is pending.
- `sent_count`  out  CNT_W  completed messages; wraps modulo 2^CNT_W.
- `drop_count`  out  CNT_W  verdicts discarded for lack of space; saturates at all-ones.

## Operation
- Event detection:
  - Registered copies `accept_q` and `reject_q`.
  - `ev_ok = accept & ~accept_q`.
  - `ev_err = reject & ~reject_q`.
  - Consecutive rejects with `reject` held high produce one ERR only.
  - If both edges occur in the same cycle, OK is taken and ERR is dropped (`drop_count` +1).
- Messages, fixed in a constant ROM:
  - OK = 0x4F 0x4B 0x0D 0x0A (length 4).
  - ERR = 0x45 0x52 0x52 0x0D 0x0A (length 5).
- State:
  - FSM states IDLE and SEND.
  - `msg_sel` (current message), 3-bit `idx` (byte index).
  - One-entry pending slot: `pend_v`, `pend_sel`.
- IDLE:
  - On an event: load `msg_sel`, set `idx`=0, go to SEND.
  - Pending slot is always empty in IDLE.
- SEND:
  - `tx_valid`=1 and `tx_data`=ROM[`msg_sel`][`idx`].
  - A byte transfers when `tx_valid & tx_ready`.
  - On a non-last transfer: `idx`+1.
  - On last-byte transfer:
    - `sent_count`+1.
    - If `pend_v`: load `pend_sel`, set `idx`=0, clear `pend_v`, stay in SEND.
    - Else if an event occurs this cycle: load it directly, stay in SEND.
    - Else go to IDLE.
- Event arriving in SEND, other than the direct load above:
  - If `pend_v`=0: write it to the pending slot.
  - If `pend_v`=1: drop it (`drop_count`+1, saturating).
  - If `pend_v`=1 and it is the last-byte cycle: the pending entry is consumed and the new event is written into the slot, so nothing is dropped.
- `busy` = (state==SEND) | `pend_v`.
- Reset (`rst`=1 at a clock edge):
  - State=IDLE; `idx`, `msg_sel`, `pend_v` cleared.
  - `accept_q`=0, `reject_q`=0.
  - Any message in flight is abandoned with no completion count.

## Timing
- Reset values:
  - `tx_valid`=0, `tx_data`=0x00, `busy`=0.
  - `sent_count`=0, `drop_count`=0.
- All outputs are registered.
- Latency: edge sampled at cycle N gives `tx_valid`=1 with the first byte at N+1.
- Throughput: with `tx_ready` held high, one byte per cycle.
- Back-to-back messages have no idle cycle: the last byte of message A at cycle M is followed by the first byte of message B at M+1.
- Handshake rules:
  - While `tx_valid & ~tx_ready`, `tx_data` and `tx_valid` are held stable.
  - `tx_valid` never drops before the transfer.
- `tx_valid` falls the cycle after the final transfer when nothing is pending.
- When `tx_valid`=0, `tx_data` holds its last value (0x00 after reset).
- Edges present while `rst`=1 are ignored. `accept_q`/`reject_q` reload from the inputs on the first non-reset cycle, so a level already high when reset releases is an event on that cycle.

## Test plan
- Reset, `tx_ready`=1; rise `accept` at N -> `tx_data` 0x4F,0x4B,0x0D,0x0A on N+1..N+4 with `tx_valid`=1; `tx_valid`=0 at N+5; `sent_count`=1, `busy`=0.
- Rise `reject`, hold `tx_ready`=0 for 3 cycles while on byte index 1 -> `tx_data`=0x52 is stable across the stall; full stream 0x45,0x52,0x52,0x0D,0x0A; `sent_count`=1.
- Rise `reject` during byte 2 of OK -> ERR's first byte (0x45) follows the 0x0A transfer on the next cycle; `busy` stays 1 throughout; `sent_count`=2.
- During OK, with `tx_ready`=0, produce three further edges (ERR, OK, ERR) -> first is queued, `drop_count`=2; after release exactly OK then ERR are emitted.
- Rise `accept` and `reject` in the same cycle -> only OK is emitted; `drop_count`=1.
- Assert `rst` during byte 2 of ERR -> `tx_valid`=0 the next cycle, `sent_count` unchanged at 0; a fresh `accept` edge then emits 0x4F first.

Source files
------------

// File: rtl/grammar_responder_if.sv
// Byte-stream handshake between the grammar responder and the UART transmitter.
interface grammar_responder_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/grammar_responder.sv
// Grammar responder: turns validator accept/reject edges into "OK\r\n" /
// "ERR\r\n" byte streams on a valid/ready transmit interface, with a
// one-entry pending slot for verdicts that arrive mid-message.
module grammar_responder #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 accept,
    input  logic                 reject,
    grammar_responder_if.master  tx,
    output logic                 busy,
    output logic [CNT_W-1:0]     sent_count,
    output logic [CNT_W-1:0]     drop_count
);

    localparam logic MSG_OK  = 1'b0;
    localparam logic MSG_ERR = 1'b1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state, state_n;
    logic        accept_q, reject_q;
    logic        msg_sel, msg_sel_n;
    logic [2:0]  idx, idx_n;
    logic        pend_v, pend_v_n;
    logic        pend_sel, pend_sel_n;
    logic        sent_inc;
    logic [1:0]  drop_inc;

    logic        ev_ok, ev_err, ev_any, ev_sel, xfer, last;

    // Constant message ROM indexed by message select and byte index.
    function automatic logic [7:0] rom_byte(input logic sel, input logic [2:0] i);
        logic [7:0] b;
        case ({sel, i})
            {MSG_OK,  3'd0}: b = 8'h4F;
            {MSG_OK,  3'd1}: b = 8'h4B;
            {MSG_OK,  3'd2}: b = 8'h0D;
            {MSG_OK,  3'd3}: b = 8'h0A;
            {MSG_ERR, 3'd0}: b = 8'h45;
            {MSG_ERR, 3'd1}: b = 8'h52;
            {MSG_ERR, 3'd2}: b = 8'h52;
            {MSG_ERR, 3'd3}: b = 8'h0D;
            {MSG_ERR, 3'd4}: b = 8'h0A;
            default:         b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic is_last(input logic sel, input logic [2:0] i);
        return (sel == MSG_ERR) ? (i == 3'd4) : (i == 3'd3);
    endfunction

    // Drop counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign ev_ok  = accept & ~accept_q;
    assign ev_err = reject & ~reject_q;
    assign ev_any = ev_ok | ev_err;
    assign ev_sel = ev_ok ? MSG_OK : MSG_ERR;   // OK wins a simultaneous pair
    assign xfer   = tx.tx_valid & tx.tx_ready;
    assign last   = is_last(msg_sel, idx);

    // Next-state, byte index, pending slot and counter increments.
    always_comb begin
        state_n    = state;
        msg_sel_n  = msg_sel;
        idx_n      = idx;
        pend_v_n   = pend_v;
        pend_sel_n = pend_sel;
        sent_inc   = 1'b0;
        drop_inc   = {1'b0, ev_ok & ev_err};
        case (state)
            IDLE: begin
                if (ev_any) begin
                    msg_sel_n = ev_sel;
                    idx_n     = 3'd0;
                    state_n   = SEND;
                end
            end
            SEND: begin
                if (xfer && last) begin
                    sent_inc = 1'b1;
                    if (pend_v) begin
                        // Pending entry is consumed, freeing the slot for a new event.
                        msg_sel_n = pend_sel;
                        idx_n     = 3'd0;
                        pend_v_n  = ev_any;
                        if (ev_any) pend_sel_n = ev_sel;
                    end else if (ev_any) begin
                        msg_sel_n = ev_sel;
                        idx_n     = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (xfer) idx_n = idx + 3'd1;
                    if (ev_any) begin
                        if (!pend_v) begin
                            pend_v_n   = 1'b1;
                            pend_sel_n = ev_sel;
                        end else begin
                            drop_inc = drop_inc + 2'd1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered state, edge detectors, counters and transmit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            accept_q    <= 1'b0;
            reject_q    <= 1'b0;
            msg_sel     <= MSG_OK;
            idx         <= 3'd0;
            pend_v      <= 1'b0;
            pend_sel    <= MSG_OK;
            sent_count  <= '0;
            drop_count  <= '0;
            busy        <= 1'b0;
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= 8'h00;
        end else begin
            state       <= state_n;
            accept_q    <= accept;
            reject_q    <= reject;
            msg_sel     <= msg_sel_n;
            idx         <= idx_n;
            pend_v      <= pend_v_n;
            pend_sel    <= pend_sel_n;
            sent_count  <= sent_count + {{(CNT_W-1){1'b0}}, sent_inc};
            drop_count  <= sat_add(drop_count, drop_inc);
            busy        <= (state_n == SEND) | pend_v_n;
            tx.tx_valid <= (state_n == SEND);
            if (state_n == SEND) tx.tx_data <= rom_byte(msg_sel_n, idx_n);
        end
    end

endmodule

// File: tb/tb_grammar_responder.sv
// Directed, table-driven bench for grammar_responder.
module tb_grammar_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       accept, reject;
    logic       busy;
    logic [7:0] sent_count, drop_count;

    grammar_responder_if tx_if ();

    grammar_responder #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .accept     (accept),
        .reject     (reject),
        .tx         (tx_if.master),
        .busy       (busy),
        .sent_count (sent_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, acc, rej, rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_busy;
        logic [7:0] e_sent, e_drop;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, a, j, y, v, input logic [7:0] d,
                       input logic b, input logic [7:0] s, dr);
        vec_t t;
        t.rst = r; t.acc = a; t.rej = j; t.rdy = y;
        t.e_valid = v; t.e_data = d; t.e_busy = b; t.e_sent = s; t.e_drop = dr;
        vecs.push_back(t);
    endtask

    // Drive one cycle of inputs, let one clock edge pass, compare outputs.
    task automatic apply(input vec_t t, input string name);
        rst = t.rst; accept = t.acc; reject = t.rej; tx_if.tx_ready = t.rdy;
        @(posedge clk);
        #1;
        n_vec++;
        if (tx_if.tx_valid !== t.e_valid || tx_if.tx_data !== t.e_data ||
            busy !== t.e_busy || sent_count !== t.e_sent || drop_count !== t.e_drop) begin
            n_bad++;
            $display("FAIL %s: got valid=%b data=%h busy=%b sent=%0d drop=%0d, want valid=%b data=%h busy=%b sent=%0d drop=%0d",
                     name, tx_if.tx_valid, tx_if.tx_data, busy, sent_count, drop_count,
                     t.e_valid, t.e_data, t.e_busy, t.e_sent, t.e_drop);
        end
    endtask

    initial begin
        vec_t t;
        rst = 1'b1; accept = 1'b0; reject = 1'b0; tx_if.tx_ready = 1'b1;

        //   rst acc rej rdy | valid data  busy sent drop
        // reset
        add(1, 0, 0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 0, 0, 1,  0, 8'h00, 0, 0, 0);
        // OK message, ready held high
        add(0, 1, 0, 1,  1, 8'h4F, 1, 0, 0);
        add(0, 1, 0, 1,  1, 8'h4B, 1, 0, 0);
        add(0, 1, 0, 1,  1, 8'h0D, 1, 0, 0);
        add(0, 1, 0, 1,  1, 8'h0A, 1, 0, 0);
        add(0, 1, 0, 1,  0, 8'h0A, 0, 1, 0);
        add(0, 0, 0, 1,  0, 8'h0A, 0, 1, 0);
        // ERR with a 3-cycle stall on byte index 1
        add(0, 0, 1, 1,  1, 8'h45, 1, 1, 0);
        add(0, 0, 1, 1,  1, 8'h52, 1, 1, 0);
        add(0, 0, 1, 0,  1, 8'h52, 1, 1, 0);
        add(0, 0, 1, 0,  1, 8'h52, 1, 1, 0);
        add(0, 0, 1, 0,  1, 8'h52, 1, 1, 0);
        add(0, 0, 1, 1,  1, 8'h52, 1, 1, 0);
        add(0, 0, 1, 1,  1, 8'h0D, 1, 1, 0);
        add(0, 0, 1, 1,  1, 8'h0A, 1, 1, 0);
        add(0, 0, 1, 1,  0, 8'h0A, 0, 2, 0);
        add(0, 0, 1, 1,  0, 8'h0A, 0, 2, 0);   // held reject: no second ERR
        // OK, then reject rises mid-message: ERR follows with no gap
        add(0, 0, 0, 1,  0, 8'h0A, 0, 2, 0);
        add(0, 1, 0, 1,  1, 8'h4F, 1, 2, 0);
        add(0, 1, 0, 1,  1, 8'h4B, 1, 2, 0);
        add(0, 1, 1, 1,  1, 8'h0D, 1, 2, 0);
        add(0, 1, 1, 1,  1, 8'h0A, 1, 2, 0);
        add(0, 1, 1, 1,  1, 8'h45, 1, 3, 0);
        add(0, 1, 1, 1,  1, 8'h52, 1, 3, 0);
        add(0, 1, 1, 1,  1, 8'h52, 1, 3, 0);
        add(0, 1, 1, 1,  1, 8'h0D, 1, 3, 0);
        add(0, 1, 1, 1,  1, 8'h0A, 1, 3, 0);
        add(0, 1, 1, 1,  0, 8'h0A, 0, 4, 0);
        // Stalled OK with ERR, OK, ERR edges: first queued, two dropped
        add(0, 0, 0, 1,  0, 8'h0A, 0, 4, 0);
        add(0, 1, 0, 0,  1, 8'h4F, 1, 4, 0);
        add(0, 1, 1, 0,  1, 8'h4F, 1, 4, 0);
        add(0, 0, 1, 0,  1, 8'h4F, 1, 4, 0);
        add(0, 1, 0, 0,  1, 8'h4F, 1, 4, 1);
        add(0, 1, 1, 0,  1, 8'h4F, 1, 4, 2);
        add(0, 1, 1, 1,  1, 8'h4B, 1, 4, 2);
        add(0, 1, 1, 1,  1, 8'h0D, 1, 4, 2);
        add(0, 1, 1, 1,  1, 8'h0A, 1, 4, 2);
        add(0, 1, 1, 1,  1, 8'h45, 1, 5, 2);
        add(0, 1, 1, 1,  1, 8'h52, 1, 5, 2);
        add(0, 1, 1, 1,  1, 8'h52, 1, 5, 2);
        add(0, 1, 1, 1,  1, 8'h0D, 1, 5, 2);
        add(0, 1, 1, 1,  1, 8'h0A, 1, 5, 2);
        add(0, 1, 1, 1,  0, 8'h0A, 0, 6, 2);
        add(0, 1, 1, 1,  0, 8'h0A, 0, 6, 2);
        // Simultaneous accept and reject edges: OK only, one drop
        add(0, 0, 0, 1,  0, 8'h0A, 0, 6, 2);
        add(0, 1, 1, 1,  1, 8'h4F, 1, 6, 3);
        add(0, 1, 1, 1,  1, 8'h4B, 1, 6, 3);
        add(0, 1, 1, 1,  1, 8'h0D, 1, 6, 3);
        add(0, 1, 1, 1,  1, 8'h0A, 1, 6, 3);
        add(0, 1, 1, 1,  0, 8'h0A, 0, 7, 3);
        add(0, 1, 1, 1,  0, 8'h0A, 0, 7, 3);

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-ERR abandons the message without counting it.
        t = '{rst:1, acc:0, rej:0, rdy:1, e_valid:0, e_data:8'h00, e_busy:0, e_sent:0, e_drop:0};
        apply(t, "rst_clear");
        t = '{rst:0, acc:0, rej:1, rdy:1, e_valid:1, e_data:8'h45, e_busy:1, e_sent:0, e_drop:0};
        apply(t, "err_b0");
        t.e_data = 8'h52; apply(t, "err_b1");
        t.e_data = 8'h52; apply(t, "err_b2");
        t = '{rst:1, acc:0, rej:1, rdy:1, e_valid:0, e_data:8'h00, e_busy:0, e_sent:0, e_drop:0};
        apply(t, "rst_mid_err");
        t = '{rst:0, acc:1, rej:0, rdy:1, e_valid:1, e_data:8'h4F, e_busy:1, e_sent:0, e_drop:0};
        apply(t, "fresh_ok_b0");
        t.e_data = 8'h4B; apply(t, "fresh_ok_b1");
        t.e_data = 8'h0D; apply(t, "fresh_ok_b2");
        t.e_data = 8'h0A; apply(t, "fresh_ok_b3");
        t = '{rst:0, acc:1, rej:0, rdy:1, e_valid:0, e_data:8'h0A, e_busy:0, e_sent:1, e_drop:0};
        apply(t, "fresh_ok_done");

        // Level already high while in reset is an event on the first free cycle.
        t = '{rst:1, acc:1, rej:0, rdy:1, e_valid:0, e_data:8'h00, e_busy:0, e_sent:0, e_drop:0};
        apply(t, "rst_with_acc");
        t = '{rst:0, acc:1, rej:0, rdy:1, e_valid:1, e_data:8'h4F, e_busy:1, e_sent:0, e_drop:0};
        apply(t, "acc_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
